// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: sequences read-then-write accesses to the single-port row FIFO of the
// PNG filter stage. Define LINE_BUF_CTRL_NBR_EN to add left/upper-left neighbour outputs.
module line_buf_ctrl #(
    parameter int unsigned DATA_WD   = 8,
    parameter int unsigned SIZE_W_WD = 16,
    parameter int unsigned SIZE_H_WD = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SIZE_W_WD-1:0] cfg_w_i,
    input  logic [SIZE_H_WD-1:0] cfg_h_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 pix_val_i,
    input  logic [DATA_WD-1:0]   pix_dat_i,
    output logic                 pix_rdy_o,
    output logic                 fifo_wr_val_o,
    output logic [DATA_WD-1:0]   fifo_wr_dat_o,
    output logic                 fifo_rd_val_o,
    input  logic [DATA_WD-1:0]   fifo_rd_dat_i,
    output logic                 out_val_o,
    output logic [DATA_WD-1:0]   out_cur_o,
    output logic [DATA_WD-1:0]   out_up_o,
`ifdef LINE_BUF_CTRL_NBR_EN
    output logic [DATA_WD-1:0]   out_left_o,
    output logic [DATA_WD-1:0]   out_upleft_o,
`endif
    output logic                 out_sol_o,
    output logic                 out_eol_o
);

    typedef enum logic [1:0] {IDLE, ACC, WRB} state_t;

    localparam logic [SIZE_W_WD-1:0] W_ONE = SIZE_W_WD'(1);
    localparam logic [SIZE_H_WD-1:0] H_ONE = SIZE_H_WD'(1);

    state_t               state_q, state_d;
    logic [SIZE_H_WD-1:0] cfg_h_q;
    logic [SIZE_H_WD-1:0] row_q;
    logic [SIZE_W_WD-1:0] col_q;
    logic [DATA_WD-1:0]   cur_q;
    logic                 col_end, row_end, last_pix, row0;

    assign col_end  = (col_q == cfg_w_i - W_ONE);
    assign row_end  = (row_q == cfg_h_q - H_ONE);
    assign last_pix = col_end && row_end;
    assign row0     = (row_q == '0);

    assign busy_o        = (state_q != IDLE);
    assign fifo_wr_dat_o = cur_q;

    always_comb begin
        state_d       = state_q;
        pix_rdy_o     = 1'b0;
        fifo_rd_val_o = 1'b0;
        fifo_wr_val_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = ACC;
            end
            ACC: begin
                pix_rdy_o = 1'b1;
                if (pix_val_i) begin
                    // read is issued in the accept cycle so data lands during WRB
                    fifo_rd_val_o = !row0;
                    state_d       = WRB;
                end
            end
            WRB: begin
                fifo_wr_val_o = 1'b1;
                state_d       = last_pix ? IDLE : ACC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_h_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cur_q        <= '0;
            done_o       <= 1'b0;
            out_val_o    <= 1'b0;
            out_cur_o    <= '0;
            out_up_o     <= '0;
            out_sol_o    <= 1'b0;
            out_eol_o    <= 1'b0;
`ifdef LINE_BUF_CTRL_NBR_EN
            out_left_o   <= '0;
            out_upleft_o <= '0;
`endif
        end else begin
            out_val_o <= 1'b0;
            done_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cfg_h_q <= cfg_h_i;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                ACC: begin
                    if (pix_val_i) cur_q <= pix_dat_i;
                end
                WRB: begin
                    out_val_o <= 1'b1;
                    out_cur_o <= cur_q;
                    out_up_o  <= row0 ? '0 : fifo_rd_dat_i;
                    out_sol_o <= (col_q == '0);
                    out_eol_o <= col_end;
                    done_o    <= last_pix;
`ifdef LINE_BUF_CTRL_NBR_EN
                    // previous output pair of the same row becomes the neighbour pair
                    out_left_o   <= (col_q == '0) ? '0 : out_cur_o;
                    out_upleft_o <= (col_q == '0) ? '0 : out_up_o;
`endif
                    if (col_end) begin
                        col_q <= '0;
                        if (!row_end) row_q <= row_q + H_ONE;
                    end else begin
                        col_q <= col_q + W_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl: frame-level pixel model plus a behavioural row FIFO.
module tb_line_buf_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned WW = 16;
    localparam int unsigned HW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [WW-1:0] cfg_w_i = '0;
    logic [HW-1:0] cfg_h_i = '0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o;
    logic          pix_val_i = 1'b0;
    logic [DW-1:0] pix_dat_i = '0;
    logic          pix_rdy_o;
    logic          fifo_wr_val_o, fifo_rd_val_o;
    logic [DW-1:0] fifo_wr_dat_o;
    logic [DW-1:0] fifo_rd_dat_i;
    logic          out_val_o, out_sol_o, out_eol_o;
    logic [DW-1:0] out_cur_o, out_up_o;
`ifdef LINE_BUF_CTRL_NBR_EN
    logic [DW-1:0] out_left_o, out_upleft_o;
`endif

    always #5 clk = ~clk;

    line_buf_ctrl #(.DATA_WD(DW), .SIZE_W_WD(WW), .SIZE_H_WD(HW)) dut (
        .clk(clk), .rstn(rstn), .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i),
        .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .pix_val_i(pix_val_i), .pix_dat_i(pix_dat_i), .pix_rdy_o(pix_rdy_o),
        .fifo_wr_val_o(fifo_wr_val_o), .fifo_wr_dat_o(fifo_wr_dat_o),
        .fifo_rd_val_o(fifo_rd_val_o), .fifo_rd_dat_i(fifo_rd_dat_i),
        .out_val_o(out_val_o), .out_cur_o(out_cur_o), .out_up_o(out_up_o),
`ifdef LINE_BUF_CTRL_NBR_EN
        .out_left_o(out_left_o), .out_upleft_o(out_upleft_o),
`endif
        .out_sol_o(out_sol_o), .out_eol_o(out_eol_o)
    );

    // Row FIFO: one memory, read and write pointers both wrapping at the row width.
    logic [DW-1:0] fmem [0:63];
    int unsigned   frd, fwr;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frd <= 0; fwr <= 0; fifo_rd_dat_i <= '0;
        end else begin
            if (fifo_rd_val_o) begin
                fifo_rd_dat_i <= fmem[frd];
                frd <= (frd + 1 >= cfg_w_i) ? 0 : frd + 1;
            end
            if (fifo_wr_val_o) begin
                fmem[fwr] <= fifo_wr_dat_o;
                fwr <= (fwr + 1 >= cfg_w_i) ? 0 : fwr + 1;
            end
        end
    end

    typedef struct {
        logic [DW-1:0] cur, up, left, upleft;
        logic          sol, eol, done;
    } exp_t;

    exp_t          exp_q[$];
    int            acc_cyc_q[$];
    logic [DW-1:0] px [0:63];
    int            checks = 0, errors = 0;
    int            cyc = 0;
    int unsigned   m_w = 1, acc_cnt = 0;
    bit            prev_hs = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    int unsigned   obs_n = 0;
    logic [DW-1:0] obs_cur [0:63], obs_up [0:63], ref_cur [0:3], ref_up [0:3];
    int            obs_cyc [0:63];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Compare process: every cycle, outputs against the frame model.
    always @(negedge clk) begin
        bit   hs;
        int   a;
        exp_t e;
        cyc++;
        if (!rstn) begin
            chk("reset_outputs", {busy_o, done_o, pix_rdy_o, fifo_rd_val_o, fifo_wr_val_o,
                fifo_wr_dat_o, out_val_o, out_cur_o, out_up_o, out_sol_o, out_eol_o}, 32'd0);
`ifdef LINE_BUF_CTRL_NBR_EN
            chk("reset_nbr", {out_left_o, out_upleft_o}, 32'd0);
`endif
            prev_hs = 1'b0;
        end else begin
            hs = pix_val_i && pix_rdy_o;
            chk("rd_wr_excl", fifo_rd_val_o && fifo_wr_val_o, 0);
            chk("fifo_rd", fifo_rd_val_o, hs && (acc_cnt / m_w != 0));
            chk("fifo_wr", fifo_wr_val_o, prev_hs);
            if (prev_hs) chk("fifo_wr_dat", fifo_wr_dat_o, prev_dat);
            if (hs) begin
                acc_cyc_q.push_back(cyc);
                acc_cnt++;
            end
            prev_hs  = hs;
            prev_dat = pix_dat_i;
            if (out_val_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    a = (acc_cyc_q.size() != 0) ? acc_cyc_q.pop_front() : -100;
                    chk("latency", cyc - a, 2);
                    chk("out_cur", out_cur_o, e.cur);
                    chk("out_up", out_up_o, e.up);
                    chk("out_sol", out_sol_o, e.sol);
                    chk("out_eol", out_eol_o, e.eol);
                    chk("done", done_o, e.done);
                    chk("busy", busy_o, !e.done);
`ifdef LINE_BUF_CTRL_NBR_EN
                    chk("out_left", out_left_o, e.left);
                    chk("out_upleft", out_upleft_o, e.upleft);
`endif
                    if (obs_n < 64) begin
                        obs_cur[obs_n] = out_cur_o;
                        obs_up[obs_n]  = out_up_o;
                        obs_cyc[obs_n] = cyc;
                        obs_n++;
                    end
                end
            end else begin
                chk("done_without_out", done_o, 0);
            end
        end
    end

    // Builds the frame's expected output list from px[], then pulses start_i.
    task automatic start_frame(int unsigned w, int unsigned h);
        exp_t e;
        for (int unsigned k = 0; k < w * h; k++) begin
            int unsigned r = k / w;
            int unsigned c = k % w;
            e.cur    = px[k];
            e.up     = (r != 0) ? px[k - w] : '0;
            e.left   = (c != 0) ? px[k - 1] : '0;
            e.upleft = (r != 0 && c != 0) ? px[k - w - 1] : '0;
            e.sol    = (c == 0);
            e.eol    = (c == w - 1);
            e.done   = (k == w * h - 1);
            exp_q.push_back(e);
        end
        m_w     = w;
        acc_cnt = 0;
        cfg_w_i = WW'(w);
        cfg_h_i = HW'(h);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic feed(int unsigned n, int unsigned gap);
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned t = 0;
            if (k != 0) repeat (gap) begin
                pix_val_i = 1'b0;
                @(posedge clk); #1;
            end
            pix_val_i = 1'b1;
            pix_dat_i = px[k];
            @(negedge clk);
            while (!pix_rdy_o && t < 40) begin
                t++;
                @(negedge clk);
            end
            if (!pix_rdy_o) begin
                chk("accept_timeout", 0, 1);
                pix_val_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        pix_val_i = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic load_px(int unsigned n, int unsigned base);
        for (int unsigned k = 0; k < n; k++) px[k] = DW'(base + k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("post_reset_busy", busy_o, 0);
        chk("post_reset_rdy", pix_rdy_o, 0);

        // Single row, held valid.
        load_px(4, 1); obs_n = 0;
        start_frame(4, 1); feed(4, 0); drain();
        chk("t1_count", obs_n, 4);
        chk("t1_cur3", obs_cur[3], 8'd4);
        chk("t1_up3", obs_up[3], 8'd0);
        chk("t1_rate", obs_cyc[3] - obs_cyc[0], 6);

        // 3x3 frame.
        load_px(9, 10); obs_n = 0;
        start_frame(3, 3);
        chk("model_up4", exp_q[4].up, 8'd11);
        chk("model_upleft8", exp_q[8].upleft, 8'd14);
        feed(9, 0); drain();
        chk("t2_up3", obs_up[3], 8'd10);
        chk("t2_up5", obs_up[5], 8'd12);
        chk("t2_up8", obs_up[8], 8'd15);
        chk("t2_cur8", obs_cur[8], 8'd18);

        // One pixel per row.
        load_px(4, 5); obs_n = 0;
        start_frame(1, 4);
        chk("model_w1_sol_eol", {exp_q[2].sol, exp_q[2].eol}, 2'b11);
        feed(4, 0); drain();
        chk("t3_up1", obs_up[1], 8'd5);
        chk("t3_up3", obs_up[3], 8'd7);

        // Unstalled versus gapped stream.
        load_px(4, 8'h31); obs_n = 0;
        start_frame(2, 2); feed(4, 0); drain();
        for (int i = 0; i < 4; i++) begin
            ref_cur[i] = obs_cur[i];
            ref_up[i]  = obs_up[i];
        end
        obs_n = 0;
        start_frame(2, 2); feed(4, 2); drain();
        for (int i = 0; i < 4; i++) begin
            chk("t4_gap_cur", obs_cur[i], ref_cur[i]);
            chk("t4_gap_up", obs_up[i], ref_up[i]);
        end
        chk("t4_up2", obs_up[2], 8'h31);

        // Frame B started in frame A's done cycle; stray start while busy.
        load_px(4, 8'h41); obs_n = 0;
        start_frame(2, 2); feed(4, 0);
        @(posedge clk); #1;
        chk("t5_done_cycle", done_o, 1);
        load_px(4, 8'h51);
        start_frame(2, 2);
        chk("t5_busy_b", busy_o, 1);
        cfg_h_i = HW'(9);
        start_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 start_i = 1'b0;
        cfg_h_i = HW'(2);
        feed(4, 0); drain();
        chk("t5_count", obs_n, 8);
        chk("t5_b_up0", obs_up[4], 8'd0);
        chk("t5_b_up2", obs_up[6], 8'h51);
        chk("t5_idle", busy_o, 0);

        // Reset in the middle of row 1, then a fresh frame.
        load_px(4, 1); obs_n = 0;
        start_frame(2, 2); feed(3, 0);
        rstn = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
        acc_cnt = 0;
        #1;
        chk("t6_async_busy", busy_o, 0);
        chk("t6_async_wr", fifo_wr_val_o, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        load_px(4, 8'h21); obs_n = 0;
        start_frame(2, 2); feed(4, 0); drain();
        chk("t6_up0", obs_up[0], 8'd0);
        chk("t6_up2", obs_up[2], 8'h21);
        chk("t6_cur3", obs_cur[3], 8'h24);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
# line_buf_ctrl

Sequencer for the single-port row FIFO used by the PNG filter stage. It accepts the raw pixel stream and, per pixel, reads the previous-row pixel from the FIFO, then writes the current pixel into the same slot. It presents the current/up pixel pair (optionally left/upper-left) to the filter datapath. It sits between the pixel source and the filter, and owns all FIFO write/read strobes.

## Interface
- DATA_WD, 8, pixel/FIFO word width in bits.
- SIZE_H_WD, 16, width of row-count configuration.
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_w_i  in  `SIZE_W_WD`  pixels per row, ≥1; also drives FIFO cfg_w_i; stable while busy_o.
- cfg_h_i  in  SIZE_H_WD  rows per frame, ≥1; sampled on accepted start_i.
- start_i  in  1  frame start pulse; ignored while busy_o=1.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse with final out_val_o of frame.
- pix_val_i  in  1  input pixel valid.
- pix_dat_i  in  DATA_WD  input pixel.
- pix_rdy_o  out  1  input pixel accepted when pix_val_i & pix_rdy_o.
- fifo_wr_val_o  out  1  FIFO write strobe.
- fifo_wr_dat_o  out  DATA_WD  FIFO write data.
- fifo_rd_val_o  out  1  FIFO read strobe.
- fifo_rd_dat_i  in  DATA_WD  FIFO read data, valid 1 cycle after fifo_rd_val_o.
- out_val_o  out  1  output pair valid; no backpressure.
- out_cur_o  out  DATA_WD  current pixel.
- out_up_o  out  DATA_WD  pixel directly above; 0 in row 0.
- out_sol_o / out_eol_o  out  1  first / last pixel of row, qualified by out_val_o.

## Operation
- FSM states: IDLE, ACC, WRB.
- IDLE: pix_rdy_o=0; start_i → latch cfg_h_i, col=0, row=0, busy_o=1, go ACC.
- ACC: pix_rdy_o=1. On handshake: register pixel to cur_r; assert fifo_rd_val_o iff row≠0; go WRB. No handshake: stay.
- WRB: pix_rdy_o=0; fifo_wr_val_o=1 with fifo_wr_dat_o=cur_r; fifo_rd_val_o=0; capture up = (row≠0) ? fifo_rd_dat_i : 0. Advance col; at col==cfg_w_i−1, col→0 and row+1. If last pixel (row==h−1, col==w−1) go IDLE, else ACC.
- fifo_wr_val_o and fifo_rd_val_o are never high in the same cycle (single-port FIFO address mux).
- Read precedes write of the same slot, so FIFO rd/wr pointers (both wrapping at cfg_w_i) stay aligned; row 0 issues no reads, so both pointers are at 0 when row 1 starts.
- Counters: col is `SIZE_W_WD` bits, row is SIZE_H_WD bits; compare against cfg−1, no overflow beyond.
- Abort is by rstn only; rstn also resets FIFO pointers, keeping them aligned.

## Timing
- Reset values: all outputs 0 (busy_o, done_o, pix_rdy_o, fifo strobes, fifo_wr_dat_o, out_* all 0); FSM=IDLE; counters 0.
- Throughput: 1 pixel per 2 cycles while pix_val_i is held.
- Latency: pixel accepted at cycle t → FIFO write at t+1 → out_val_o at t+2 (registered outputs).
- done_o and busy_o fall: done_o=1 at the final out_val_o cycle. busy_o=0 from that same cycle. start_i is accepted the same cycle done_o is high.
- w=1: every pixel is both sol and eol; read and write both target slot 0.
- rstn asserted mid-frame: outputs return to reset values asynchronously; any in-flight pixel is lost.

## Configuration
- LINE_BUF_CTRL_NBR_EN defined: adds out_left_o and out_upleft_o (out, DATA_WD), registered with out_val_o. out_left_o = previous out_cur_o in the row, 0 at col 0. out_upleft_o = previous out_up_o in the row, 0 at col 0 or row 0. Required for the Paeth filter.
- Undefined: ports and registers are absent; the rest of the behaviour is identical.

## Test plan
- w=4, h=1, pixels 1..4, pix_val_i held → out_val_o every 2 cycles; cur=1..4, up=0; no fifo_rd_val_o; done_o with pixel 4.
- w=3, h=3, pixels 10..18 → row1 up=10,11,12; row2 up=13,14,15; sol/eol on cols 0/2; rd and wr strobes never coincide.
- w=1, h=4, pixels 5,6,7,8 → up=0,5,6,7; sol=eol=1 every output.
- Gapped input (pix_val_i toggling 1,0,0,1…) with w=2, h=2 → same out data as the unstalled run; FSM holds in ACC during gaps.
- Start frame A (w=2, h=2), then assert start_i in the done_o cycle with frame B → B row0 up=0. With NBR_EN: B row1 upleft uses B data only. start_i pulsed while busy → ignored.
- rstn low mid-row1, then new frame w=2, h=2 → outputs 0 during reset; new frame correct, row0 up=0.
